// File: rtl/stack_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : stack_pkg                                                    |
// | Description : Shared helpers for the parametrised LIFO stack: ceil-log2    |
// |               function, default count width and the push/pop op encoding.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package stack_pkg;

    // Ceiling log2; clog2(1) = 0, clog2(9) = 4.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    localparam int c_DEF_DEPTH = 8;
    localparam int c_DEF_CNT_W = clog2(c_DEF_DEPTH + 1);

    // Operation decoded directly from {Push, Pop}.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_SWAP = 2'b11
    } stack_op_t;

    function automatic stack_op_t decode_op(input logic push, input logic pop);
        return stack_op_t'({push, pop});
    endfunction

endpackage
`default_nettype wire

// File: rtl/stack_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : stack_ram                                                    |
// | Description : WIDTH x DEPTH storage, one synchronous write port and one    |
// |               asynchronous read port. Contents are not reset.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module stack_ram #(
    parameter int WIDTH  = 5,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Synchronous write of one entry.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/param_stack.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : param_stack                                                  |
// | Description : Parametrised LIFO stack with occupancy count, flags,         |
// |               replace-top (push+pop), flush, error pulses and peek.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module param_stack
    import stack_pkg::*;
#(
    parameter int WIDTH     = 5,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = 6
) (
    input  logic                            clk,
    input  logic                            Rst,
    input  logic                            Clear,
    input  logic                            Push,
    input  logic                            Pop,
    input  logic [WIDTH-1:0]                Data_In,
    output logic [WIDTH-1:0]                Data_Out,
    output logic                            Valid_Out,
    output logic [WIDTH-1:0]                Top,
    output logic [clog2(DEPTH+1)-1:0]       Count,
    output logic                            Full,
    output logic                            Empty,
    output logic                            Almost_Full,
    output logic                            Overflow,
    output logic                            Underflow
);

    localparam int c_CNT_W  = clog2(DEPTH + 1);
    localparam int c_ADDR_W = clog2(DEPTH);

    logic [c_CNT_W-1:0]  r_count;
    logic [WIDTH-1:0]    r_data_out;
    logic                r_valid;
    logic                r_overflow;
    logic                r_underflow;

    stack_op_t           w_op;
    logic                w_full;
    logic                w_empty;
    logic                w_we;
    logic [c_ADDR_W-1:0] w_top_addr;
    logic [c_ADDR_W-1:0] w_waddr;
    logic [WIDTH-1:0]    w_rdata;

    assign w_op    = decode_op(Push, Pop);
    assign w_full  = (r_count == c_CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);

    // Address of the current top entry; held at 0 when empty so the read
    // index never leaves the array for non power-of-two depths.
    assign w_top_addr = w_empty ? '0 : (c_ADDR_W'(r_count) - c_ADDR_W'(1));

    // Push writes just above the top; replace-top overwrites the top itself.
    assign w_waddr = (w_op == OP_PUSH) ? c_ADDR_W'(r_count) : w_top_addr;
    assign w_we    = !Rst && !Clear &&
                     (((w_op == OP_PUSH) && !w_full) ||
                      ((w_op == OP_SWAP) && !w_empty));

    stack_ram #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (c_ADDR_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (Data_In),
        .i_raddr (w_top_addr),
        .o_rdata (w_rdata)
    );

    // Occupancy, popped word and one-cycle status pulses.
    always_ff @(posedge clk) begin
        if (Rst) begin
            r_count     <= '0;
            r_data_out  <= '0;
            r_valid     <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_valid     <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            if (Clear) begin
                r_count <= '0;
            end else begin
                case (w_op)
                    OP_IDLE: begin
                    end
                    OP_PUSH: begin
                        if (w_full) begin
                            r_overflow <= 1'b1;
                        end else begin
                            r_count <= r_count + c_CNT_W'(1);
                        end
                    end
                    OP_POP: begin
                        if (w_empty) begin
                            r_underflow <= 1'b1;
                        end else begin
                            r_data_out <= w_rdata;
                            r_valid    <= 1'b1;
                            r_count    <= r_count - c_CNT_W'(1);
                        end
                    end
                    OP_SWAP: begin
                        // Empty stack passes the input straight through.
                        r_data_out <= w_empty ? Data_In : w_rdata;
                        r_valid    <= 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign Data_Out    = r_data_out;
    assign Valid_Out   = r_valid;
    assign Top         = w_empty ? '0 : w_rdata;
    assign Count       = r_count;
    assign Full        = w_full;
    assign Empty       = w_empty;
    assign Almost_Full = (r_count >= c_CNT_W'(AF_THRESH));
    assign Overflow    = r_overflow;
    assign Underflow   = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_param_stack.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_param_stack                                               |
// | Description : Self-checking bench for param_stack (WIDTH=5, DEPTH=4,       |
// |               AF_THRESH=3): directed scenarios plus random traffic against |
// |               a queue-based reference model.                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_param_stack;

    localparam int WIDTH     = 5;
    localparam int DEPTH     = 4;
    localparam int AF_THRESH = 3;

    logic             clk;
    logic             rst;
    logic             clear;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             valid_out;
    logic [WIDTH-1:0] top;
    logic [2:0]       count;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             overflow;
    logic             underflow;

    int n_checks = 0;
    int n_fail   = 0;

    param_stack #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .AF_THRESH (AF_THRESH)
    ) dut (
        .clk         (clk),
        .Rst         (rst),
        .Clear       (clear),
        .Push        (push),
        .Pop         (pop),
        .Data_In     (din),
        .Data_Out    (dout),
        .Valid_Out   (valid_out),
        .Top         (top),
        .Count       (count),
        .Full        (full),
        .Empty       (empty),
        .Almost_Full (almost_full),
        .Overflow    (overflow),
        .Underflow   (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the stack is a queue whose back is the top.
    logic [WIDTH-1:0] m_q [$];
    logic [WIDTH-1:0] m_dout  = '0;
    logic             m_valid = 1'b0;
    logic             m_ovf   = 1'b0;
    logic             m_unf   = 1'b0;
    bit               m_live  = 1'b0;

    always @(posedge clk) begin
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        if (rst) begin
            m_q.delete();
            m_dout = '0;
            m_live = 1'b1;
        end else if (clear) begin
            m_q.delete();
        end else if (push && !pop) begin
            if (m_q.size() == DEPTH) m_ovf = 1'b1;
            else m_q.push_back(din);
        end else if (pop && !push) begin
            if (m_q.size() == 0) begin
                m_unf = 1'b1;
            end else begin
                m_dout  = m_q.pop_back();
                m_valid = 1'b1;
            end
        end else if (pop && push) begin
            m_valid = 1'b1;
            if (m_q.size() == 0) begin
                m_dout = din;
            end else begin
                m_dout = m_q.pop_back();
                m_q.push_back(din);
            end
        end
    end

    function automatic int m_count();
        return m_q.size();
    endfunction

    function automatic int m_top();
        return (m_q.size() == 0) ? 0 : int'(m_q[m_q.size()-1]);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of the DUT against the model, away from the edge.
    always @(negedge clk) begin
        if (m_live) begin
            chk("count",       int'(count),       m_count());
            chk("top",         int'(top),         m_top());
            chk("empty",       int'(empty),       int'(m_count() == 0));
            chk("full",        int'(full),        int'(m_count() == DEPTH));
            chk("almost_full", int'(almost_full), int'(m_count() >= AF_THRESH));
            chk("data_out",    int'(dout),        int'(m_dout));
            chk("valid_out",   int'(valid_out),   int'(m_valid));
            chk("overflow",    int'(overflow),    int'(m_ovf));
            chk("underflow",   int'(underflow),   int'(m_unf));
        end
    end

    // Apply one cycle of inputs, return just after the following falling edge.
    task automatic step(input logic r, input logic c, input logic pu,
                        input logic po, input logic [WIDTH-1:0] d);
        rst   = r;
        clear = c;
        push  = pu;
        pop   = po;
        din   = d;
        @(negedge clk);
        #1;
    endtask

    task automatic do_push(input logic [WIDTH-1:0] d);
        step(1'b0, 1'b0, 1'b1, 1'b0, d);
    endtask

    task automatic do_pop();
        step(1'b0, 1'b0, 1'b0, 1'b1, '0);
    endtask

    task automatic do_swap(input logic [WIDTH-1:0] d);
        step(1'b0, 1'b0, 1'b1, 1'b1, d);
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; push = 1'b0; pop = 1'b0; din = '0;
        @(negedge clk);
        #1;

        // 1: reset state
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full",  int'(full), 0);
        chk("rst_dout",  int'(dout), 0);
        chk("rst_valid", int'(valid_out), 0);
        chk("rst_top",   int'(top), 0);

        // 2: LIFO ordering
        do_push(5'h15);
        do_push(5'h1F);
        chk("t2_top", int'(top), 'h1F);
        do_pop();
        chk("t2_pop1",       int'(dout), 'h1F);
        chk("t2_pop1_model", int'(m_dout), 'h1F);
        chk("t2_valid1",     int'(valid_out), 1);
        do_pop();
        chk("t2_pop2",  int'(dout), 'h15);
        chk("t2_valid2", int'(valid_out), 1);
        chk("t2_empty", int'(empty), 1);

        // 3: flags and overflow
        do_push(5'd1);
        do_push(5'd2);
        chk("t3_af_at2", int'(almost_full), 0);
        do_push(5'd3);
        chk("t3_af_at3", int'(almost_full), 1);
        chk("t3_full_at3", int'(full), 0);
        do_push(5'd4);
        chk("t3_full_at4", int'(full), 1);
        do_push(5'd5);
        chk("t3_ovf",       int'(overflow), 1);
        chk("t3_ovf_model", int'(m_ovf), 1);
        chk("t3_top",       int'(top), 4);
        chk("t3_count",     int'(count), 4);
        step(1'b0, 1'b0, 1'b0, 1'b0, '0);
        chk("t3_ovf_drop", int'(overflow), 0);
        step(1'b0, 1'b1, 1'b0, 1'b0, '0);

        // 4: underflow and empty bypass
        do_pop();
        chk("t4_unf",   int'(underflow), 1);
        chk("t4_valid", int'(valid_out), 0);
        chk("t4_dout",  int'(dout), 'h15);
        do_swap(5'h0A);
        chk("t4_byp_dout",  int'(dout), 'h0A);
        chk("t4_byp_count", int'(count), 0);
        chk("t4_byp_valid", int'(valid_out), 1);
        chk("t4_byp_unf",   int'(underflow), 0);

        // 5: replace-top, including at full
        do_push(5'd1);
        do_push(5'd2);
        do_push(5'd3);
        do_swap(5'h09);
        chk("t5_dout",  int'(dout), 3);
        chk("t5_top",   int'(top), 9);
        chk("t5_count", int'(count), 3);
        do_push(5'd4);
        do_swap(5'h11);
        chk("t5f_dout",  int'(dout), 4);
        chk("t5f_top",   int'(top), 'h11);
        chk("t5f_ovf",   int'(overflow), 0);
        chk("t5f_count", int'(count), 4);

        // 6: clear beats push, reset beats pop
        step(1'b0, 1'b1, 1'b0, 1'b0, '0);
        do_push(5'd1);
        do_push(5'd2);
        step(1'b0, 1'b1, 1'b1, 1'b0, 5'd7);
        chk("t6_clr_count", int'(count), 0);
        chk("t6_clr_ovf",   int'(overflow), 0);
        do_push(5'd1);
        do_push(5'd2);
        step(1'b1, 1'b0, 1'b0, 1'b1, '0);
        chk("t6_rst_valid", int'(valid_out), 0);
        chk("t6_rst_count", int'(count), 0);
        chk("t6_rst_dout",  int'(dout), 0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic r, c, pu, po;
            r  = ($urandom_range(0, 99) < 2);
            c  = ($urandom_range(0, 99) < 3);
            pu = ($urandom_range(0, 99) < 55);
            po = ($urandom_range(0, 99) < 45);
            step(r, c, pu, po, WIDTH'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
